// File: rtl/mmio_keys_pkg.sv
// Shared register layout, default key codes and reset values for the mmio_keys block.
package mmio_keys_pkg;

  localparam int CTRL_FIFO_EN = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_REL_EN  = 2;

  localparam int STAT_OVF_BIT = 7;
  localparam int STAT_CNT_W   = 5;

  localparam logic [31:0] DEFAULT_KEYMAP  = 32'h6177_7364;
  localparam logic [7:0]  RESET_LAST_CODE = 8'h73;
  localparam logic [7:0]  REL_FLAG        = 8'h80;

  // Field order mirrors the CTRL bit indices so a raw byte slice casts directly.
  typedef struct packed {
    logic rel_en;
    logic irq_en;
    logic fifo_en;
  } ctrl_t;

  function automatic logic [7:0] status_word(input logic ovf, input logic [STAT_CNT_W-1:0] cnt);
    return {ovf, 2'b00, cnt};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, stability counter, one-cycle press/release pulses on stable-level edges.
module key_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      press <= 1'b0;
      rel   <= 1'b0;
      // Any sample matching the current level restarts the stability run.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
        rel   <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_keys.sv
// Memory-mapped keypad: debounced keys become codes, delivered through an event FIFO or a
// legacy last-code register, with CTRL/STATUS registers and a level interrupt.
module mmio_keys
  import mmio_keys_pkg::*;
#(
  parameter int                    NUM_KEYS        = 4,
  parameter int                    FIFO_DEPTH      = 8,
  parameter int                    DEBOUNCE_CYCLES = 16,
  parameter logic [NUM_KEYS*8-1:0] KEYMAP          = DEFAULT_KEYMAP,
  parameter logic [15:0]           DATA_ADDR       = 16'h00ff,
  parameter logic [15:0]           CTRL_ADDR       = 16'h4003,
  parameter logic [15:0]           STATUS_ADDR     = 16'h4004
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         addr,
  input  logic                rw,
  input  logic                valid,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                hit,
  input  logic [NUM_KEYS-1:0] keys,
  output logic                irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_KEYS-1:0] ev_press, ev_rel, pend_press, pend_rel, clr_press, clr_rel;
  logic                deq_vld;
  logic [7:0]          deq_code;

  ctrl_t               ctrl, ctrl_nxt;
  logic                ovf, ovf_nxt;
  logic [CW-1:0]       count, count_nxt;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [7:0]          last_code, rd_dat;

  logic acc_data, acc_ctrl, acc_stat, mapped, pop, push, push_ok, full, flush;
  logic data_in_unused;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock   (clock),
      .reset   (reset),
      .key_raw (keys[g]),
      .press   (ev_press[g]),
      .rel     (ev_rel[g])
    );
  end

  // Lowest pending press wins; otherwise the lowest pending release.
  always_comb begin
    deq_code  = '0;
    clr_press = '0;
    clr_rel   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_rel[k]) begin
        clr_rel    = '0;
        clr_rel[k] = 1'b1;
        deq_code   = KEYMAP[k*8 +: 8] | REL_FLAG;
      end
    end
    if (|pend_press) begin
      clr_rel = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
        if (pend_press[k]) begin
          clr_press    = '0;
          clr_press[k] = 1'b1;
          deq_code     = KEYMAP[k*8 +: 8];
        end
      end
    end
    deq_vld = (|pend_press) | (|pend_rel);
  end

  assign data_in_unused = ^data_in[7:3];

  assign acc_data = valid && (addr == DATA_ADDR);
  assign acc_ctrl = valid && (addr == CTRL_ADDR);
  assign acc_stat = valid && (addr == STATUS_ADDR);
  assign mapped   = acc_data | acc_ctrl | acc_stat;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = acc_data && rw && ctrl.fifo_en && (count != '0);
  assign push    = deq_vld && ctrl.fifo_en;
  assign push_ok = push && (!full || pop);
  assign flush   = acc_ctrl && !rw && ctrl.fifo_en && !data_in[CTRL_FIFO_EN];

  always_comb begin
    ctrl_nxt  = (acc_ctrl && !rw) ? ctrl_t'(data_in[2:0]) : ctrl;
    // A drop in the same cycle as a STATUS read keeps the flag set.
    ovf_nxt   = (push && full && !pop) | (ovf & ~(acc_stat && rw));
    count_nxt = flush ? '0 : count + CW'(push_ok) - CW'(pop);
    rd_dat    = last_code;
    if (acc_data) rd_dat = pop ? mem[rd_ptr] : last_code;
    else if (acc_ctrl) rd_dat = {5'b0, ctrl};
    else if (acc_stat) rd_dat = status_word(ovf, STAT_CNT_W'(count));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      hit        <= 1'b0;
      irq        <= 1'b0;
      ctrl       <= '0;
      ovf        <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_press <= '0;
      pend_rel   <= '0;
      last_code  <= RESET_LAST_CODE;
    end else begin
      hit        <= mapped;
      if (mapped && rw) data_out <= rd_dat;
      ctrl       <= ctrl_nxt;
      ovf        <= ovf_nxt;
      count      <= count_nxt;
      irq        <= ctrl_nxt.irq_en & ((count_nxt != '0) | ovf_nxt);
      pend_press <= (pend_press & ~clr_press) | ev_press;
      pend_rel   <= (pend_rel & ~clr_rel) | (ev_rel & {NUM_KEYS{ctrl.rel_en}});
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) last_code <= mem[rd_ptr];
      else if (deq_vld && !ctrl.fifo_en) last_code <= deq_code;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= deq_code;
  end

endmodule

// File: tb/tb_mmio_keys.sv
// Directed stimulus for mmio_keys; bus responses are checked by a queue-based monitor.
module tb_mmio_keys;

  localparam logic [15:0] DATA_A = 16'h00ff;
  localparam logic [15:0] CTRL_A = 16'h4003;
  localparam logic [15:0] STAT_A = 16'h4004;

  logic        clock, reset, rw, valid, hit, irq;
  logic [15:0] addr;
  logic [7:0]  data_in, data_out;
  logic [3:0]  keys;

  typedef struct {
    logic       chk;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mmio_keys dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .rw       (rw),
    .valid    (valid),
    .data_in  (data_in),
    .data_out (data_out),
    .hit      (hit),
    .keys     (keys),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    exp_q.push_back('{chk: 1'b1, val: e});
    addr = a; rw = 1'b1; data_in = 8'h00; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{chk: 1'b0, val: 8'h00});
    addr = a; rw = 1'b0; data_in = d; valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
  endtask

  task automatic tap(input int k);
    keys[k] = 1'b0;
    idle(25);
    keys[k] = 1'b1;
    idle(25);
  endtask

  // Monitor: every hit consumes one expected response, in issue order.
  always @(negedge clock) begin
    if (!reset && hit) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hit actual=hit required=no_hit addr=%0h", addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) chk("rd_data", {24'h0, data_out}, {24'h0, e.val});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; valid = 1'b0; rw = 1'b1; addr = 16'h0; data_in = 8'h0; keys = 4'hF;
    idle(3);
    chk("rst_data_out", {24'h0, data_out}, 32'h0);
    chk("rst_hit", {31'h0, hit}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    idle(2);

    // Legacy mode
    rd(DATA_A, 8'h73);
    keys[1] = 1'b0; idle(30); keys[1] = 1'b1; idle(30);
    rd(DATA_A, 8'h73);
    keys[0] = 1'b0; idle(30);
    rd(DATA_A, 8'h64);
    rd(DATA_A, 8'h64);
    keys[0] = 1'b1; idle(30);
    rd(DATA_A, 8'h64);
    wr(DATA_A, 8'h55);
    rd(DATA_A, 8'h64);
    wr(STAT_A, 8'hff);
    rd(STAT_A, 8'h00);
    addr = 16'h00fe; rw = 1'b1; valid = 1'b1;
    @(posedge clock); #1; valid = 1'b0;
    idle(1);
    chk("unmapped_hold", {24'h0, data_out}, 32'h0);
    chk("unmapped_hit", {31'h0, hit}, 32'h0);

    // Bounce on key2 in FIFO mode: only the final steady press counts
    wr(CTRL_A, 8'h01);
    rd(CTRL_A, 8'h01);
    for (int i = 0; i < 20; i++) begin
      keys[2] = ~keys[2];
      idle(5);
    end
    keys[2] = 1'b0; idle(30);
    rd(STAT_A, 8'h01);
    rd(DATA_A, 8'h77);
    rd(STAT_A, 8'h00);
    keys[2] = 1'b1; idle(30);

    // Simultaneous presses on keys 0,1,3
    keys = 4'b0100; idle(30);
    rd(STAT_A, 8'h03);
    rd(DATA_A, 8'h64);
    rd(STAT_A, 8'h02);
    rd(DATA_A, 8'h73);
    rd(STAT_A, 8'h01);
    rd(DATA_A, 8'h61);
    rd(STAT_A, 8'h00);
    rd(DATA_A, 8'h61);
    rd(DATA_A, 8'h61);
    keys = 4'hF; idle(30);

    // Overflow: nine presses into an 8-deep FIFO
    for (int i = 0; i < 9; i++) tap(i % 4);
    rd(STAT_A, 8'h88);
    rd(STAT_A, 8'h08);

    // Full FIFO: key1 event enqueues on the same edge as a DATA pop
    keys[1] = 1'b0;
    idle(19);
    rd(DATA_A, 8'h64);
    idle(2);
    rd(STAT_A, 8'h08);
    rd(DATA_A, 8'h73);
    rd(DATA_A, 8'h77);
    rd(DATA_A, 8'h61);
    rd(DATA_A, 8'h64);
    rd(DATA_A, 8'h73);
    rd(DATA_A, 8'h77);
    rd(DATA_A, 8'h61);
    rd(DATA_A, 8'h73);
    rd(STAT_A, 8'h00);
    keys[1] = 1'b1; idle(30);

    // Releases and interrupt
    wr(CTRL_A, 8'h07);
    rd(CTRL_A, 8'h07);
    idle(1);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    tap(3);
    chk("irq_pending", {31'h0, irq}, 32'h1);
    rd(STAT_A, 8'h02);
    rd(DATA_A, 8'h61);
    chk("irq_one_left", {31'h0, irq}, 32'h1);
    rd(DATA_A, 8'he1);
    idle(1);
    chk("irq_drained", {31'h0, irq}, 32'h0);

    // Leaving FIFO mode flushes without touching last_code
    tap(0);
    rd(STAT_A, 8'h02);
    chk("irq_before_flush", {31'h0, irq}, 32'h1);
    wr(CTRL_A, 8'h00);
    rd(STAT_A, 8'h00);
    rd(CTRL_A, 8'h00);
    chk("irq_after_flush", {31'h0, irq}, 32'h0);
    rd(DATA_A, 8'he1);

    // Reset in the middle of a DATA read
    wr(CTRL_A, 8'h01);
    tap(0);
    rd(STAT_A, 8'h01);
    idle(2);
    addr = DATA_A; rw = 1'b1; valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_data_out", {24'h0, data_out}, 32'h0);
    chk("midrst_hit", {31'h0, hit}, 32'h0);
    @(posedge clock); #1; valid = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(2);
    rd(STAT_A, 8'h00);
    rd(CTRL_A, 8'h00);
    rd(DATA_A, 8'h73);

    idle(3);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
